// File: rtl/cbfp0_reorder_buf.sv
// Ping-pong reorder buffer after the stage-0 CBFP normaliser: collects 4 beats x 16 lanes
// per 64-point block and re-emits them in stride-4 (transposed) order with the block shifts.
module cbfp0_reorder_buf #(
  parameter int unsigned DATA_WIDTH  = 11,
  parameter int unsigned SHIFT_WIDTH = 5,
  parameter int unsigned LANES       = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          din_valid,
  input  logic signed [DATA_WIDTH-1:0]  din_real [0:LANES-1],
  input  logic signed [DATA_WIDTH-1:0]  din_imag [0:LANES-1],
  input  logic        [SHIFT_WIDTH-1:0] shift_re_in,
  input  logic        [SHIFT_WIDTH-1:0] shift_im_in,
  output logic                          valid_out,
  output logic signed [DATA_WIDTH-1:0]  dout_real [0:LANES-1],
  output logic signed [DATA_WIDTH-1:0]  dout_imag [0:LANES-1],
  output logic        [SHIFT_WIDTH-1:0] shift_re_out,
  output logic        [SHIFT_WIDTH-1:0] shift_im_out,
  output logic        [7:0]             blk_cnt
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_READ = 1'b1;

  // Storage index is {bank, row, lane} on write and {bank, lane, row} on read.
  logic signed [DATA_WIDTH-1:0]  r_mem_re [0:127];
  logic signed [DATA_WIDTH-1:0]  r_mem_im [0:127];
  logic        [SHIFT_WIDTH-1:0] r_sh_re  [0:1];
  logic        [SHIFT_WIDTH-1:0] r_sh_im  [0:1];

  logic [1:0] r_wcnt;
  logic       r_wbank;
  logic [1:0] r_full;
  logic       r_state;
  logic       r_rbank;
  logic [1:0] r_rcnt;

  logic                          r_valid;
  logic signed [DATA_WIDTH-1:0]  r_dout_re [0:LANES-1];
  logic signed [DATA_WIDTH-1:0]  r_dout_im [0:LANES-1];
  logic        [SHIFT_WIDTH-1:0] r_shift_re;
  logic        [SHIFT_WIDTH-1:0] r_shift_im;
  logic        [7:0]             r_blk_cnt;

  logic       w_wr_done;
  logic       w_rd_go;
  logic       w_rd_bank;
  logic [1:0] w_rd_cnt;
  logic       w_rd_done;
  logic [1:0] w_full_nxt;

  assign w_wr_done = din_valid && (r_wcnt == 2'd3);

  // Idle entry emits beat 0 immediately, so a newly full bank costs no bubble.
  // With both banks full the older one is the one the writer will hit next.
  assign w_rd_go   = (r_state == ST_READ) || (r_full != 2'b00);
  assign w_rd_bank = (r_state == ST_READ) ? r_rbank :
                     ((&r_full) ? r_wbank : r_full[1]);
  assign w_rd_cnt  = (r_state == ST_READ) ? r_rcnt : 2'd0;
  assign w_rd_done = w_rd_go && (w_rd_cnt == 2'd3);

  always_comb begin
    w_full_nxt = r_full;
    if (w_rd_done) w_full_nxt[w_rd_bank] = 1'b0;
    if (w_wr_done) w_full_nxt[r_wbank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (din_valid) begin
      for (int l = 0; l < LANES; l++) begin
        r_mem_re[{r_wbank, r_wcnt, 4'(l)}] <= din_real[l];
        r_mem_im[{r_wbank, r_wcnt, 4'(l)}] <= din_imag[l];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wcnt   <= 2'd0;
      r_wbank  <= 1'b0;
      r_full   <= 2'b00;
      r_sh_re  <= '{default: '0};
      r_sh_im  <= '{default: '0};
    end else begin
      r_full <= w_full_nxt;
      if (din_valid) r_wcnt <= r_wcnt + 2'd1;
      if (w_wr_done) begin
        r_sh_re[r_wbank] <= shift_re_in;
        r_sh_im[r_wbank] <= shift_im_in;
        r_wbank          <= ~r_wbank;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_rbank    <= 1'b0;
      r_rcnt     <= 2'd0;
      r_valid    <= 1'b0;
      r_dout_re  <= '{default: '0};
      r_dout_im  <= '{default: '0};
      r_shift_re <= '0;
      r_shift_im <= '0;
      r_blk_cnt  <= 8'd0;
    end else if (w_rd_go) begin
      r_state    <= w_rd_done ? ST_IDLE : ST_READ;
      r_rbank    <= w_rd_bank;
      r_rcnt     <= w_rd_cnt + 2'd1;
      r_valid    <= 1'b1;
      r_shift_re <= r_sh_re[w_rd_bank];
      r_shift_im <= r_sh_im[w_rd_bank];
      for (int l = 0; l < LANES; l++) begin
        r_dout_re[l] <= r_mem_re[{w_rd_bank, 4'(l), w_rd_cnt}];
        r_dout_im[l] <= r_mem_im[{w_rd_bank, 4'(l), w_rd_cnt}];
      end
      if (w_rd_done) r_blk_cnt <= r_blk_cnt + 8'd1;
    end else begin
      r_state    <= ST_IDLE;
      r_rcnt     <= 2'd0;
      r_valid    <= 1'b0;
      r_dout_re  <= '{default: '0};
      r_dout_im  <= '{default: '0};
      r_shift_re <= '0;
      r_shift_im <= '0;
    end
  end

  assign valid_out    = r_valid;
  assign dout_real    = r_dout_re;
  assign dout_imag    = r_dout_im;
  assign shift_re_out = r_shift_re;
  assign shift_im_out = r_shift_im;
  assign blk_cnt      = r_blk_cnt;

  // A write into a still-full bank is only safe if that bank's last beat leaves this cycle.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rstn)
    din_valid |-> !(r_full[r_wbank] && !(w_rd_done && (w_rd_bank == r_wbank))))
    else $error("reorder buffer overflow: write into full bank %0d", r_wbank);

endmodule
